// File: rtl/hp_cfg_tlp_rx.sv
// Decodes host MWr TLPs (1-2 DW, BAR0) from the TRN rx link into huge-page descriptor registers.
// Optional HP_CFG_ERRFWD_DROP_EN: drop TLPs that are poisoned (EP) or error-forwarded.
module hp_cfg_tlp_rx (
    input  logic        trn_clk,
    input  logic        reset_n,
    input  logic [63:0] trn_rd,
    input  logic [7:0]  trn_rrem_n,
    input  logic        trn_rsof_n,
    input  logic        trn_reof_n,
    input  logic        trn_rsrc_rdy_n,
    output logic        trn_rdst_rdy_n,
    input  logic        trn_rerrfwd_n,
    input  logic [6:0]  trn_rbar_hit_n,
    output logic [63:0] huge_page_addr_1,
    output logic [63:0] huge_page_addr_2,
    output logic        huge_page_status_1,
    output logic        huge_page_status_2,
    input  logic        huge_page_free_1,
    input  logic        huge_page_free_2,
    output logic        interrupts_enabled
);

    typedef enum logic [1:0] {S_IDLE, S_HDR2, S_DATA, S_DRAIN} state_t;

    localparam logic [6:0] FT_MWR3 = 7'b100_0000;
    localparam logic [6:0] FT_MWR4 = 7'b110_0000;

    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    state_t      state;
    logic        beat, sof, eof;
    logic [6:0]  hdr_ft;
    logic [9:0]  hdr_len;
    logic        candidate;

    logic        is_4dw_p0, len2_p0;
    logic [9:0]  off_p0;
    logic [31:0] dw0_p0;

    logic        cm_vld, cm_two, cm_drop;
    logic [9:0]  cm_off;
    logic [31:0] cm_dw0, cm_dw1;
    logic [4:0]  wr_hit;
    logic [31:0] wr_val [5];

    assign beat   = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
    assign sof    = beat && !trn_rsof_n;
    assign eof    = !trn_reof_n;
    assign hdr_ft  = trn_rd[62:56];
    assign hdr_len = trn_rd[41:32];
    assign candidate = (hdr_ft == FT_MWR3 || hdr_ft == FT_MWR4) &&
                       (hdr_len == 10'd1 || hdr_len == 10'd2) && !trn_rbar_hit_n[0];

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            trn_rdst_rdy_n <= 1'b1;
        end else begin
            trn_rdst_rdy_n <= 1'b0;
            if (sof) begin
                // A new SOF always restarts decode, whatever was in flight
                if (eof)            state <= S_IDLE;
                else if (candidate) state <= S_HDR2;
                else                state <= S_DRAIN;
            end else if (beat) begin
                case (state)
                    S_HDR2: begin
                        if (eof)            state <= S_IDLE;
                        else if (is_4dw_p0) state <= (trn_rd[63:32] == 32'h0) ? S_DATA : S_DRAIN;
                        else                state <= len2_p0 ? S_DATA : S_DRAIN;
                    end
                    S_DATA:  state <= eof ? S_IDLE : S_DRAIN;
                    S_DRAIN: if (eof) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Stage p0: header fields and first payload DW captured for the commit beat
    always_ff @(posedge trn_clk) begin
        if (sof) begin
            is_4dw_p0 <= hdr_ft[5];
            len2_p0   <= (hdr_len == 10'd2);
        end
        if (beat && !sof && state == S_HDR2) begin
            off_p0 <= is_4dw_p0 ? trn_rd[11:2] : trn_rd[43:34];
            dw0_p0 <= trn_rd[31:0];
        end
    end

    always_comb begin
        cm_vld = 1'b0;
        cm_off = off_p0;
        cm_dw0 = dw0_p0;
        cm_dw1 = trn_rd[63:32];
        cm_two = len2_p0;
        if (beat && !sof && eof) begin
            case (state)
                S_HDR2: begin
                    if (!is_4dw_p0 && !len2_p0 && trn_rrem_n == 8'h00) begin
                        cm_vld = 1'b1;
                        cm_off = trn_rd[43:34];
                        cm_dw0 = trn_rd[31:0];
                        cm_two = 1'b0;
                    end
                end
                S_DATA: begin
                    // Last beat carries only the upper DW unless it is a 4DW header with 2 DWs
                    if (trn_rrem_n == ((!is_4dw_p0 || !len2_p0) ? 8'h0F : 8'h00)) begin
                        cm_vld = 1'b1;
                        if (is_4dw_p0) begin
                            cm_dw0 = trn_rd[63:32];
                            cm_dw1 = trn_rd[31:0];
                        end
                    end
                end
                default: cm_vld = 1'b0;
            endcase
        end
    end

`ifdef HP_CFG_ERRFWD_DROP_EN
    logic err_p0;
    logic unused_in;

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n)  err_p0 <= 1'b0;
        else if (sof)  err_p0 <= trn_rd[46] || !trn_rerrfwd_n;
        else if (beat) err_p0 <= err_p0 || !trn_rerrfwd_n;
    end

    assign cm_drop   = err_p0 || !trn_rerrfwd_n;
    assign unused_in = ^trn_rbar_hit_n[6:1];
`else
    logic unused_in;
    assign cm_drop   = 1'b0;
    assign unused_in = ^{trn_rbar_hit_n[6:1], trn_rerrfwd_n};
`endif

    // 11-bit compare so a DW1 past the last offset never wraps onto register 0
    always_comb begin
        for (int r = 0; r < 5; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = byte_swap(cm_dw0);
            if (cm_vld && !cm_drop) begin
                if (cm_off == 10'(r)) begin
                    wr_hit[r] = 1'b1;
                end else if (cm_two && ({1'b0, cm_off} + 11'd1) == 11'(r)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = byte_swap(cm_dw1);
                end
            end
        end
    end

    // Stage p1: architectural registers; writes use the status from before this edge
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            huge_page_addr_1   <= 64'h0;
            huge_page_addr_2   <= 64'h0;
            huge_page_status_1 <= 1'b0;
            huge_page_status_2 <= 1'b0;
            interrupts_enabled <= 1'b0;
        end else begin
            if (wr_hit[0] && !huge_page_status_1) huge_page_addr_1[31:0]  <= wr_val[0];
            if (wr_hit[1] && !huge_page_status_1) huge_page_addr_1[63:32] <= wr_val[1];
            if (wr_hit[2] && !huge_page_status_2) huge_page_addr_2[31:0]  <= wr_val[2];
            if (wr_hit[3] && !huge_page_status_2) huge_page_addr_2[63:32] <= wr_val[3];

            if (huge_page_free_1)  huge_page_status_1 <= 1'b0;
            else if (wr_hit[1])    huge_page_status_1 <= 1'b1;
            if (huge_page_free_2)  huge_page_status_2 <= 1'b0;
            else if (wr_hit[3])    huge_page_status_2 <= 1'b1;

            if (wr_hit[4]) interrupts_enabled <= wr_val[4][0];
        end
    end

endmodule

// File: tb/tb_hp_cfg_tlp_rx.sv
// Directed bench for hp_cfg_tlp_rx: table of TLP vectors plus hand sequences for reset/restart cases.
module tb_hp_cfg_tlp_rx;

    localparam logic [6:0] MW3  = 7'b100_0000;
    localparam logic [6:0] MW4  = 7'b110_0000;
    localparam logic [6:0] MRD  = 7'b000_0000;
    localparam logic [6:0] BAR0 = 7'b111_1110;
    localparam logic [6:0] BAR1 = 7'b111_1101;
`ifdef HP_CFG_ERRFWD_DROP_EN
    localparam bit DROP_EP = 1'b1;
`else
    localparam bit DROP_EP = 1'b0;
`endif

    logic        trn_clk = 1'b0;
    logic        reset_n;
    logic [63:0] trn_rd;
    logic [7:0]  trn_rrem_n;
    logic        trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rdst_rdy_n, trn_rerrfwd_n;
    logic [6:0]  trn_rbar_hit_n;
    logic [63:0] huge_page_addr_1, huge_page_addr_2;
    logic        huge_page_status_1, huge_page_status_2;
    logic        huge_page_free_1, huge_page_free_2;
    logic        interrupts_enabled;

    int n_cmp = 0;
    int n_fail = 0;

    hp_cfg_tlp_rx dut (
        .trn_clk(trn_clk), .reset_n(reset_n), .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n),
        .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
        .trn_rdst_rdy_n(trn_rdst_rdy_n), .trn_rerrfwd_n(trn_rerrfwd_n),
        .trn_rbar_hit_n(trn_rbar_hit_n), .huge_page_addr_1(huge_page_addr_1),
        .huge_page_addr_2(huge_page_addr_2), .huge_page_status_1(huge_page_status_1),
        .huge_page_status_2(huge_page_status_2), .huge_page_free_1(huge_page_free_1),
        .huge_page_free_2(huge_page_free_2), .interrupts_enabled(interrupts_enabled)
    );

    always #5 trn_clk = ~trn_clk;

    typedef struct {
        string       name;
        logic [6:0]  ft;
        logic [9:0]  len;
        logic [6:0]  bar;
        logic [63:0] addr;
        logic [31:0] d0, d1;
        logic        ep, f1, f2;
        logic [63:0] ea1, ea2;
        logic        es1, es2, eirq;
    } vec_t;

    function automatic vec_t mk(string nm, logic [6:0] ft, logic [9:0] len, logic [6:0] bar,
                                logic [63:0] addr, logic [31:0] d0, logic [31:0] d1,
                                logic ep, logic f1, logic f2, logic [63:0] ea1,
                                logic [63:0] ea2, logic es1, logic es2, logic eirq);
        vec_t v;
        v.name = nm; v.ft = ft; v.len = len; v.bar = bar; v.addr = addr;
        v.d0 = d0; v.d1 = d1; v.ep = ep; v.f1 = f1; v.f2 = f2;
        v.ea1 = ea1; v.ea2 = ea2; v.es1 = es1; v.es2 = es2; v.eirq = eirq;
        return v;
    endfunction

    function automatic logic [31:0] hdr0(logic [6:0] ft, logic [9:0] len, logic ep);
        return {1'b0, ft, 8'h00, 1'b0, ep, 4'h0, len};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] ea1, input logic [63:0] ea2,
                             input logic es1, input logic es2, input logic eirq);
        check({tag, " addr_1"}, huge_page_addr_1, ea1);
        check({tag, " addr_2"}, huge_page_addr_2, ea2);
        check({tag, " status_1"}, {63'h0, huge_page_status_1}, {63'h0, es1});
        check({tag, " status_2"}, {63'h0, huge_page_status_2}, {63'h0, es2});
        check({tag, " irq_en"}, {63'h0, interrupts_enabled}, {63'h0, eirq});
        check({tag, " rdst_rdy_n"}, {63'h0, trn_rdst_rdy_n}, 64'h0);
    endtask

    task automatic set_idle();
        trn_rsrc_rdy_n   = 1'b1;
        trn_rsof_n       = 1'b1;
        trn_reof_n       = 1'b1;
        trn_rrem_n       = 8'h00;
        trn_rd           = 64'h0;
        huge_page_free_1 = 1'b0;
        huge_page_free_2 = 1'b0;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic sof_n, input logic eof_n,
                              input logic [7:0] rrem);
        trn_rd         = d;
        trn_rsof_n     = sof_n;
        trn_reof_n     = eof_n;
        trn_rrem_n     = rrem;
        trn_rsrc_rdy_n = 1'b0;
        @(posedge trn_clk);
        #1;
        set_idle();
    endtask

    task automatic send_tlp(input logic [6:0] ft, input logic [9:0] len, input logic [6:0] bar,
                            input logic [63:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                            input logic ep, input logic f1, input logic f2);
        logic [31:0] dws[$];
        int n, nb;
        logic last;
        dws.push_back(hdr0(ft, len, ep));
        dws.push_back(32'h0000_00FF);
        if (ft[5]) begin
            dws.push_back(addr[63:32]);
            dws.push_back(addr[31:0]);
        end else begin
            dws.push_back(addr[31:0]);
        end
        if (ft[6])
            for (int k = 0; k < int'(len); k++)
                dws.push_back(k == 0 ? d0 : (k == 1 ? d1 : 32'hA5A5_A5A5));
        n  = dws.size();
        nb = (n + 1) / 2;
        trn_rbar_hit_n = bar;
        for (int b = 0; b < nb; b++) begin
            last = (b == nb - 1);
            huge_page_free_1 = last & f1;
            huge_page_free_2 = last & f2;
            drive_beat({dws[2*b], (2*b + 1 < n) ? dws[2*b+1] : 32'h0}, (b != 0), !last,
                       (last && (n % 2 == 1)) ? 8'h0F : 8'h00);
        end
    endtask

    vec_t vecs[15];

    initial begin
        // Expected register state after each vector is cumulative
        vecs[0]  = mk("hp1 3dw len2", MW3, 10'd2, BAR0, 64'h00, 32'h7856_3412, 32'h0, 0, 0, 0,
                      64'h0000_0000_1234_5678, 64'h0, 1, 0, 0);
        vecs[1]  = mk("hp2 lo 4dw", MW4, 10'd1, BAR0, 64'h08, 32'hEFBE_ADDE, 32'h0, 0, 0, 0,
                      64'h0000_0000_1234_5678, 64'h0000_0000_DEAD_BEEF, 1, 0, 0);
        vecs[2]  = mk("hp2 hi 4dw", MW4, 10'd1, BAR0, 64'h0C, 32'h0100_0000, 32'h0, 0, 0, 0,
                      64'h0000_0000_1234_5678, 64'h0000_0001_DEAD_BEEF, 1, 1, 0);
        vecs[3]  = mk("hp2 hi owned", MW3, 10'd1, BAR0, 64'h0C, 32'h0200_0000, 32'h0, 0, 0, 0,
                      64'h0000_0000_1234_5678, 64'h0000_0001_DEAD_BEEF, 1, 1, 0);
        vecs[4]  = mk("irq on free2", MW3, 10'd1, BAR0, 64'h10, 32'h0100_0000, 32'h0, 0, 0, 1,
                      64'h0000_0000_1234_5678, 64'h0000_0001_DEAD_BEEF, 1, 0, 1);
        vecs[5]  = mk("bar1 ignored", MW3, 10'd1, BAR1, 64'h10, 32'h0, 32'h0, 0, 0, 0,
                      64'h0000_0000_1234_5678, 64'h0000_0001_DEAD_BEEF, 1, 0, 1);
        vecs[6]  = mk("len4 ignored", MW3, 10'd4, BAR0, 64'h10, 32'h0, 32'h0, 0, 0, 0,
                      64'h0000_0000_1234_5678, 64'h0000_0001_DEAD_BEEF, 1, 0, 1);
        vecs[7]  = mk("mrd ignored", MRD, 10'd1, BAR0, 64'h10, 32'h0, 32'h0, 0, 0, 0,
                      64'h0000_0000_1234_5678, 64'h0000_0001_DEAD_BEEF, 1, 0, 1);
        vecs[8]  = mk("free1+hi same", MW3, 10'd1, BAR0, 64'h04, 32'h5500_0000, 32'h0, 0, 1, 0,
                      64'h0000_0000_1234_5678, 64'h0000_0001_DEAD_BEEF, 0, 0, 1);
        vecs[9]  = mk("hp1 hi", MW3, 10'd1, BAR0, 64'h04, 32'h5500_0000, 32'h0, 0, 0, 0,
                      64'h0000_0055_1234_5678, 64'h0000_0001_DEAD_BEEF, 1, 0, 1);
        vecs[10] = mk("cross 0x10", MW3, 10'd2, BAR0, 64'h10, 32'h0, 32'h0100_0000, 0, 0, 0,
                      64'h0000_0055_1234_5678, 64'h0000_0001_DEAD_BEEF, 1, 0, 0);
        vecs[11] = mk("4dw h2 nonzero", MW4, 10'd1, BAR0, 64'h1_0000_0008, 32'h1111_1111, 32'h0,
                      0, 0, 0, 64'h0000_0055_1234_5678, 64'h0000_0001_DEAD_BEEF, 1, 0, 0);
        vecs[12] = mk("free1 on mrd", MRD, 10'd1, BAR0, 64'h00, 32'h0, 32'h0, 0, 1, 0,
                      64'h0000_0055_1234_5678, 64'h0000_0001_DEAD_BEEF, 0, 0, 0);
        vecs[13] = mk("ep hp1 hi", MW3, 10'd1, BAR0, 64'h04, 32'h6600_0000, 32'h0, 1, 0, 0,
                      DROP_EP ? 64'h0000_0055_1234_5678 : 64'h0000_0066_1234_5678,
                      64'h0000_0001_DEAD_BEEF, !DROP_EP, 0, 0);
        vecs[14] = mk("hp2 4dw len2", MW4, 10'd2, BAR0, 64'h08, 32'h4433_2211, 32'h8877_6655,
                      0, 0, 0, DROP_EP ? 64'h0000_0055_1234_5678 : 64'h0000_0066_1234_5678,
                      64'h5566_7788_1122_3344, !DROP_EP, 1, 0);

        set_idle();
        trn_rerrfwd_n  = 1'b1;
        trn_rbar_hit_n = 7'h7F;
        reset_n        = 1'b0;
        repeat (3) @(posedge trn_clk);
        #1;
        check("reset rdst_rdy_n", {63'h0, trn_rdst_rdy_n}, 64'h1);
        check("reset addr_1", huge_page_addr_1, 64'h0);
        check("reset addr_2", huge_page_addr_2, 64'h0);
        check("reset status", {62'h0, huge_page_status_1, huge_page_status_2}, 64'h0);
        check("reset irq_en", {63'h0, interrupts_enabled}, 64'h0);
        reset_n = 1'b1;
        @(posedge trn_clk);
        #1;
        check("rdst after reset", {63'h0, trn_rdst_rdy_n}, 64'h0);

        for (int i = 0; i < 15; i++) begin
            send_tlp(vecs[i].ft, vecs[i].len, vecs[i].bar, vecs[i].addr, vecs[i].d0, vecs[i].d1,
                     vecs[i].ep, vecs[i].f1, vecs[i].f2);
            check_all(vecs[i].name, vecs[i].ea1, vecs[i].ea2, vecs[i].es1, vecs[i].es2,
                      vecs[i].eirq);
        end

        // Reset in the middle of a TLP, then the tail arrives without SOF
        trn_rbar_hit_n = BAR0;
        drive_beat({hdr0(MW3, 10'd2, 1'b0), 32'h0000_00FF}, 1'b0, 1'b1, 8'h00);
        drive_beat({32'h0000_0008, 32'h0100_0000}, 1'b1, 1'b1, 8'h00);
        reset_n = 1'b0;
        #2;
        check("midreset addr_2", huge_page_addr_2, 64'h0);
        check("midreset rdst_rdy_n", {63'h0, trn_rdst_rdy_n}, 64'h1);
        @(posedge trn_clk);
        #1;
        reset_n = 1'b1;
        @(posedge trn_clk);
        #1;
        drive_beat({32'h0100_0000, 32'h0}, 1'b1, 1'b0, 8'h0F);
        @(posedge trn_clk);
        #1;
        check_all("orphan tail", 64'h0, 64'h0, 0, 0, 0);
        send_tlp(MW3, 10'd1, BAR0, 64'h10, 32'h0100_0000, 32'h0, 0, 0, 0);
        check_all("after reset tlp", 64'h0, 64'h0, 0, 0, 1);

        // Back-to-back TLPs with no idle cycle between EOF and SOF
        send_tlp(MW3, 10'd1, BAR0, 64'h00, 32'h0403_0201, 32'h0, 0, 0, 0);
        send_tlp(MW3, 10'd1, BAR0, 64'h04, 32'h0D0C_0B0A, 32'h0, 0, 0, 0);
        check_all("back2back", 64'h0A0B_0C0D_0102_0304, 64'h0, 1, 0, 1);

        // SOF arriving mid-TLP abandons the old one
        drive_beat({hdr0(MW3, 10'd2, 1'b0), 32'h0000_00FF}, 1'b0, 1'b1, 8'h00);
        drive_beat({32'h0000_0010, 32'h0000_0000}, 1'b1, 1'b1, 8'h00);
        send_tlp(MW3, 10'd1, BAR0, 64'h0C, 32'h0300_0000, 32'h0, 0, 0, 0);
        check_all("sof restart", 64'h0A0B_0C0D_0102_0304, 64'h0000_0003_0000_0000, 1, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
